// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int DW_DEF     = 1;
    localparam int ERR_CNT_W  = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Saturating increment for the dropped-word counter.
    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a single word for one channel until the
// downstream consumer takes it. Free when empty or draining this cycle, so
// a load and a drain on the same edge sustain one word per cycle.
module demux_slot #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_free,
    output logic          o_drain
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_drain = r_valid & i_ready;
    assign o_free  = ~r_valid | i_ready;

    // Load wins over drain; data is left in place when the slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (o_drain) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Valid/ready stream demultiplexer: routes each accepted word to one channel
// slot (or all slots on broadcast). Out-of-range unicasts are accepted,
// dropped and counted.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEF,
    parameter  int DW     = DW_DEF,
    localparam int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_bcast,
    input  logic [DW-1:0]        in_data,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [SEL_W:0] LP_NUM_CH = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0]         w_free;
    logic [NUM_CH-1:0]         w_drain;
    logic [NUM_CH-1:0]         w_hit;
    logic [NUM_CH-1:0]         w_load;
    logic [NUM_CH-1:0]         w_valid;
    logic [NUM_CH-1:0][DW-1:0] w_slot_data;

    logic w_in_range;
    logic w_all_free;
    logic w_sel_free;
    logic w_accept;
    logic w_drop;

    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Selected slot is found through a one-hot decode so an out-of-range
    // select never indexes past the slot array.
    assign w_in_range = ({1'b0, in_sel} < LP_NUM_CH);
    assign w_all_free = &w_free;
    assign w_sel_free = |(w_free & w_hit);

    // Upstream ready: broadcast needs every slot, unicast only its target,
    // out-of-range unicast is always taken so it can be discarded.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = w_all_free;
        end else if (w_in_range) begin
            in_ready = w_sel_free;
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_drop   = w_accept & ~in_bcast & ~w_in_range;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            assign w_hit[k]  = ({1'b0, in_sel} == (SEL_W+1)'(k));
            assign w_load[k] = w_accept & (in_bcast | w_hit[k]);

            demux_slot #(
                .DW (DW)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[k]),
                .i_data  (in_data),
                .i_ready (out_ready[k]),
                .o_valid (w_valid[k]),
                .o_data  (w_slot_data[k]),
                .o_free  (w_free[k]),
                .o_drain (w_drain[k])
            );

            assign out_valid[k]          = w_valid[k];
            assign out_data[k*DW +: DW]  = w_slot_data[k];

            // A draining slot must always be reported free for reload.
            a_drain_free: assert property (@(posedge clk) disable iff (!rst_n)
                w_drain[k] |-> w_free[k]);
        end
    endgenerate

    // Count discarded out-of-range unicasts, saturating at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_drop) begin
            r_err_cnt <= err_sat_inc(r_err_cnt);
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios on an 8-channel 1-bit instance
// and a 5-channel 8-bit instance, plus randomized traffic against a
// per-channel word-pending model.
module tb_stream_demux;

    logic clk;
    logic rst_n;

    // Instance A: NUM_CH=8, DW=1
    logic        a_valid, a_in_ready, a_bcast;
    logic [2:0]  a_sel;
    logic [0:0]  a_data;
    logic [7:0]  a_out_valid, a_oready, a_out_data, a_err;

    // Instance B: NUM_CH=5, DW=8
    logic        b_valid, b_in_ready, b_bcast;
    logic [2:0]  b_sel;
    logic [7:0]  b_data, b_err;
    logic [4:0]  b_out_valid, b_oready;
    logic [39:0] b_out_data;

    int checks = 0;
    int errors = 0;

    // Reference model: which channels hold a pending word, its value, drops.
    logic       m_vld [2][16];
    logic [7:0] m_dat [2][16];
    int         m_err [2];

    stream_demux #(.NUM_CH(8), .DW(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_in_ready),
        .in_sel(a_sel), .in_bcast(a_bcast), .in_data(a_data),
        .out_valid(a_out_valid), .out_ready(a_oready), .out_data(a_out_data),
        .err_cnt(a_err));

    stream_demux #(.NUM_CH(5), .DW(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
        .in_sel(b_sel), .in_bcast(b_bcast), .in_data(b_data),
        .out_valid(b_out_valid), .out_ready(b_oready), .out_data(b_out_data),
        .err_cnt(b_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 0;
            for (int k = 0; k < 16; k++) begin
                m_vld[d][k] = 1'b0;
                m_dat[d][k] = 8'h00;
            end
        end
    endtask

    // A channel can take a word if nothing is pending there or it leaves now.
    function automatic logic exp_ready(input int d, input int nch, input logic bc,
                                       input logic [3:0] sel, input logic [15:0] ordy);
        logic all_free;
        all_free = 1'b1;
        for (int k = 0; k < nch; k++)
            if (m_vld[d][k] && !ordy[k]) all_free = 1'b0;
        if (bc) return all_free;
        if (int'(sel) >= nch) return 1'b1;
        return !m_vld[d][sel] || ordy[sel];
    endfunction

    task automatic model_step(input int d, input int nch, input logic v, input logic bc,
                              input logic [3:0] sel, input logic [7:0] data,
                              input logic [15:0] ordy);
        logic acc;
        acc = v && exp_ready(d, nch, bc, sel, ordy);
        for (int k = 0; k < nch; k++)
            if (m_vld[d][k] && ordy[k]) m_vld[d][k] = 1'b0;
        if (acc) begin
            if (bc) begin
                for (int k = 0; k < nch; k++) begin
                    m_vld[d][k] = 1'b1;
                    m_dat[d][k] = data;
                end
            end else if (int'(sel) < nch) begin
                m_vld[d][sel] = 1'b1;
                m_dat[d][sel] = data;
            end else if (m_err[d] < 255) begin
                m_err[d]++;
            end
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_bcast = 0; a_sel = 0; a_data = 0; a_oready = 8'hFF;
        b_valid = 0; b_bcast = 0; b_sel = 0; b_data = 0; b_oready = 5'h1F;
    endtask

    task automatic test_reset();
        idle_inputs();
        a_oready = 8'h00;
        a_valid = 1;
        rst_n = 0;
        #1;
        checks++; if (a_out_valid !== 8'h00) begin errors++; $display("FAIL reset_a_valid got %h exp 00", a_out_valid); end
        checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL reset_a_data got %h exp 00", a_out_data); end
        checks++; if (a_err !== 8'h00) begin errors++; $display("FAIL reset_a_err got %h exp 00", a_err); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", a_in_ready); end
        checks++; if (b_out_valid !== 5'h00 || b_err !== 8'h00) begin errors++; $display("FAIL reset_b got v=%h e=%h exp 00/00", b_out_valid, b_err); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        idle_inputs();
        model_clear();
    endtask

    task automatic test_single();
        a_sel = 3'd3; a_data = 1'b1; a_oready = 8'hFF; a_valid = 1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", a_in_ready); end
        @(posedge clk); #1;
        a_valid = 0;
        checks++; if (a_out_valid !== 8'h08) begin errors++; $display("FAIL single_valid got %h exp 08", a_out_valid); end
        checks++; if (a_out_data[3] !== 1'b1) begin errors++; $display("FAIL single_data got %b exp 1", a_out_data[3]); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'h00) begin errors++; $display("FAIL single_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_hold();
        a_oready = 8'hDF; a_sel = 3'd5; a_data = 1'b1; a_valid = 1;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'h20 || a_out_data[5] !== 1'b1) begin errors++; $display("FAIL hold_first got v=%h d=%b exp 20/1", a_out_valid, a_out_data[5]); end
        a_data = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_stall got %b exp 0", a_in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (a_out_valid !== 8'h20 || a_out_data[5] !== 1'b1 || a_in_ready !== 1'b0)
                begin errors++; $display("FAIL hold_stable got v=%h d=%b r=%b exp 20/1/0", a_out_valid, a_out_data[5], a_in_ready); end
        end
        a_oready = 8'hFF;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", a_in_ready); end
        @(posedge clk); #1;
        a_valid = 0;
        checks++; if (a_out_valid !== 8'h20 || a_out_data[5] !== 1'b0) begin errors++; $display("FAIL hold_second got v=%h d=%b exp 20/0", a_out_valid, a_out_data[5]); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'h00) begin errors++; $display("FAIL hold_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_bcast();
        a_oready = 8'hFE; a_bcast = 1; a_data = 1'b1; a_sel = 3'd6; a_valid = 1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bcast_ready got %b exp 1", a_in_ready); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'hFF || a_out_data !== 8'hFF) begin errors++; $display("FAIL bcast_load got v=%h d=%h exp FF/FF", a_out_valid, a_out_data); end
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bcast_stall got %b exp 0", a_in_ready); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (a_out_valid !== 8'h01 || a_in_ready !== 1'b0) begin errors++; $display("FAIL bcast_wait got v=%h r=%b exp 01/0", a_out_valid, a_in_ready); end
        end
        a_oready = 8'hFF;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bcast_release got %b exp 1", a_in_ready); end
        @(posedge clk); #1;
        a_valid = 0; a_bcast = 0;
        checks++; if (a_out_valid !== 8'hFF) begin errors++; $display("FAIL bcast_second got %h exp FF", a_out_valid); end
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'h00) begin errors++; $display("FAIL bcast_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'($urandom);
        pat[0] = 1'b1; pat[1] = 1'b0;
        a_oready = 8'hFF; a_sel = 3'd2; a_bcast = 0; a_valid = 1;
        for (int i = 0; i < 8; i++) begin
            a_data = pat[i];
            #1;
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, a_in_ready); end
            @(posedge clk); #1;
            checks++; if (a_out_valid !== 8'h04 || a_out_data[2] !== pat[i])
                begin errors++; $display("FAIL b2b_word[%0d] got v=%h d=%b exp 04/%b", i, a_out_valid, a_out_data[2], pat[i]); end
        end
        a_valid = 0;
        @(posedge clk); #1;
        checks++; if (a_out_valid !== 8'h00) begin errors++; $display("FAIL b2b_drain got %h exp 00", a_out_valid); end
    endtask

    task automatic test_err_sat();
        int exp_err;
        b_oready = 5'h00; b_sel = 3'd6; b_bcast = 0; b_valid = 1;
        for (int i = 0; i < 300; i++) begin
            b_data = 8'($urandom);
            #1;
            checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL err_ready[%0d] got %b exp 1", i, b_in_ready); end
            @(posedge clk); #1;
            exp_err = (i + 1 > 255) ? 255 : i + 1;
            checks++; if (b_out_valid !== 5'h00 || b_err !== 8'(exp_err))
                begin errors++; $display("FAIL err_count[%0d] got v=%h e=%0d exp 00/%0d", i, b_out_valid, b_err, exp_err); end
        end
        b_valid = 0;
        checks++; if (b_err !== 8'd255) begin errors++; $display("FAIL err_sat got %0d exp 255", b_err); end
    endtask

    task automatic test_async_reset();
        a_oready = 8'h00; a_bcast = 1; a_data = 1'b1; a_valid = 1;
        @(posedge clk); #1;
        a_valid = 0; a_bcast = 0;
        checks++; if (a_out_valid !== 8'hFF || b_err !== 8'd255) begin errors++; $display("FAIL areset_pre got v=%h e=%0d exp FF/255", a_out_valid, b_err); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (a_out_valid !== 8'h00 || a_out_data !== 8'h00) begin errors++; $display("FAIL areset_a got v=%h d=%h exp 00/00", a_out_valid, a_out_data); end
        checks++; if (b_err !== 8'h00 || b_out_valid !== 5'h00) begin errors++; $display("FAIL areset_b got e=%h v=%h exp 00/00", b_err, b_out_valid); end
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        model_clear();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            a_valid  = 1'($urandom);
            a_sel    = 3'($urandom);
            a_bcast  = ($urandom_range(0, 7) == 0);
            a_data   = 1'($urandom);
            a_oready = 8'($urandom) | 8'($urandom);
            b_valid  = 1'($urandom);
            b_sel    = 3'($urandom);
            b_bcast  = ($urandom_range(0, 7) == 0);
            b_data   = 8'($urandom);
            b_oready = 5'($urandom) | 5'($urandom);
            #1;
            checks++; if (a_in_ready !== exp_ready(0, 8, a_bcast, {1'b0, a_sel}, {8'h00, a_oready}))
                begin errors++; $display("FAIL rand_a_ready[%0d] got %b", c, a_in_ready); end
            checks++; if (b_in_ready !== exp_ready(1, 5, b_bcast, {1'b0, b_sel}, {11'h000, b_oready}))
                begin errors++; $display("FAIL rand_b_ready[%0d] got %b", c, b_in_ready); end
            model_step(0, 8, a_valid, a_bcast, {1'b0, a_sel}, {7'h00, a_data}, {8'h00, a_oready});
            model_step(1, 5, b_valid, b_bcast, {1'b0, b_sel}, b_data, {11'h000, b_oready});
            @(posedge clk); #1;
            for (int k = 0; k < 8; k++) begin
                checks++; if (a_out_valid[k] !== m_vld[0][k] || (m_vld[0][k] && a_out_data[k] !== m_dat[0][k][0]))
                    begin errors++; $display("FAIL rand_a_ch%0d[%0d] got v=%b d=%b exp %b/%b", k, c, a_out_valid[k], a_out_data[k], m_vld[0][k], m_dat[0][k][0]); end
            end
            for (int k = 0; k < 5; k++) begin
                checks++; if (b_out_valid[k] !== m_vld[1][k] || (m_vld[1][k] && b_out_data[k*8 +: 8] !== m_dat[1][k]))
                    begin errors++; $display("FAIL rand_b_ch%0d[%0d] got v=%b d=%h exp %b/%h", k, c, b_out_valid[k], b_out_data[k*8 +: 8], m_vld[1][k], m_dat[1][k]); end
            end
            checks++; if (a_err !== 8'(m_err[0]) || b_err !== 8'(m_err[1]))
                begin errors++; $display("FAIL rand_err[%0d] got a=%0d b=%0d exp %0d/%0d", c, a_err, b_err, m_err[0], m_err[1]); end
        end
        idle_inputs();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_hold();
        test_bcast();
        test_back_to_back();
        test_err_sat();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
